// File: rtl/layer_norm_stats_unit.sv
// layer_norm_stats_unit
//
// Computes the LayerNorm statistics of one D_MODEL-element activation vector:
//   mu      = floor(sum(x) / D_MODEL)                      S13.10
//   inv_std = largest y with y^2 * (var + EPS) <= 2^48     S9.14, i.e. floor(1/sqrt)
// The vector is summed NUM_LANES elements per cycle. 1/sqrt is found by a
// bit-serial successive-approximation search over the 23 magnitude bits of y.
// The search uses no LUT and no divider.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   start_stats  start request, sampled only while idle
//   x_vector_in  packed signed S5.10 vector, element i at [i*X_WIDTH +: X_WIDTH]
//   mu_out       registered mean, S13.10
//   inv_std_out  registered 1/sqrt(var+EPS), S9.14, never negative
//   stats_done   one-cycle completion pulse
//   busy         high while a run is in progress, including the stats_done cycle
//   dbg_state    current FSM state, for observation only
//
// Handshake: a run starts on any rising edge where start_stats=1 and the unit
// is idle. Requests that arrive while busy are dropped, not queued.
// x_vector_in must stay stable from the start edge through the last
// accumulate edge. Results are valid in the cycle where stats_done=1, and
// they hold until the next completion or reset.
module layer_norm_stats_unit #(
  parameter int          D_MODEL       = 128,
  parameter int          NUM_LANES     = 8,
  parameter int          X_WIDTH       = 16,
  parameter int          MU_WIDTH      = 24,
  parameter int          INV_STD_WIDTH = 24,
  parameter int unsigned EPS           = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_stats,
  input  logic [D_MODEL*X_WIDTH-1:0]   x_vector_in,
  output logic [MU_WIDTH-1:0]          mu_out,
  output logic [INV_STD_WIDTH-1:0]     inv_std_out,
  output logic                         stats_done,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam int N_CHUNKS = D_MODEL / NUM_LANES;
  localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int LOG2_D   = $clog2(D_MODEL);
  localparam int SUM_W    = 24;          // signed Q.10 running sum
  localparam int SQ_W     = 40;          // unsigned Q.20 running sum of squares
  localparam int VAR_W    = 2 * SUM_W;   // signed width holding ex2 - mu^2 exactly
  localparam int V_W      = 41;          // unsigned Q.20 var + EPS
  localparam int Y_W      = 23;          // magnitude bits of inv_std
  localparam int BIT_W    = 5;
  localparam int PROD_W   = 88;          // exact width of t^2 * v

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_VAR   = 3'd2,
    S_ISQRT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CW-1:0]            r_chunk;
  logic signed [SUM_W-1:0]  r_sum;
  logic [SQ_W-1:0]          r_sumsq;
  logic signed [SUM_W-1:0]  r_mu;
  logic [V_W-1:0]           r_v;
  logic [Y_W-1:0]           r_y;
  logic [BIT_W-1:0]         r_bit;
  logic [MU_WIDTH-1:0]      r_mu_out;
  logic [INV_STD_WIDTH-1:0] r_inv_std_out;
  logic                     r_stats_done;

  logic signed [SUM_W-1:0]  w_chunk_sum;
  logic [SQ_W-1:0]          w_chunk_sq;
  logic signed [SUM_W-1:0]  w_mu;
  logic [SQ_W-1:0]          w_ex2;
  logic signed [VAR_W-1:0]  w_mu_sq;
  logic signed [VAR_W-1:0]  w_var;
  logic [V_W-1:0]           w_var_sat;
  logic [V_W-1:0]           w_v;
  logic [Y_W-1:0]           w_t;
  logic [PROD_W-1:0]        w_prod;
  logic                     w_fit;

  // Sum and sum of squares of the chunk currently selected by r_chunk.
  always_comb begin
    w_chunk_sum = '0;
    w_chunk_sq  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      logic signed [X_WIDTH-1:0]   elem;
      logic signed [2*X_WIDTH-1:0] elem_sq;
      elem        = $signed(x_vector_in[(int'(r_chunk) * NUM_LANES + l) * X_WIDTH +: X_WIDTH]);
      elem_sq     = elem * elem;
      w_chunk_sum = w_chunk_sum + {{(SUM_W - X_WIDTH){elem[X_WIDTH-1]}}, elem};
      // A square is never negative, so zero-extension is exact.
      w_chunk_sq  = w_chunk_sq + {{(SQ_W - 2*X_WIDTH){1'b0}}, elem_sq};
    end
  end

  // Variance terms. The arithmetic shift rounds mu toward -inf. The
  // difference can come out slightly negative, so it is clamped at zero.
  always_comb begin
    w_mu    = r_sum >>> LOG2_D;
    w_ex2   = r_sumsq >> LOG2_D;
    w_mu_sq = w_mu * w_mu;
    w_var   = $signed({{(VAR_W - SQ_W){1'b0}}, w_ex2}) - w_mu_sq;
    if (w_var[VAR_W-1]) begin
      w_var_sat = '0;
    end else if (|w_var[VAR_W-2:V_W]) begin
      w_var_sat = '1;
    end else begin
      w_var_sat = w_var[V_W-1:0];
    end
    w_v = w_var_sat + V_W'(EPS);
  end

  // One successive-approximation step. Keep trial bit b if (y|b)^2 * v <= 2^48.
  // When v = 0, every trial passes and y saturates to all ones.
  always_comb begin
    w_t    = r_y | (Y_W'(1) << r_bit);
    w_prod = PROD_W'(w_t) * PROD_W'(w_t) * PROD_W'(r_v);
    w_fit  = (w_prod <= (PROD_W'(1) << 48));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_stats) w_next_state = S_ACCUM;
      S_ACCUM: if (r_chunk == CW'(N_CHUNKS - 1)) w_next_state = S_VAR;
      S_VAR:   w_next_state = S_ISQRT;
      S_ISQRT: if (r_bit == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chunk       <= '0;
      r_sum         <= '0;
      r_sumsq       <= '0;
      r_mu          <= '0;
      r_v           <= '0;
      r_y           <= '0;
      r_bit         <= '0;
      r_mu_out      <= '0;
      r_inv_std_out <= '0;
      r_stats_done  <= 1'b0;
    end else begin
      r_stats_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_chunk <= '0;
          r_sum   <= '0;
          r_sumsq <= '0;
        end
        S_ACCUM: begin
          r_sum   <= r_sum + w_chunk_sum;
          r_sumsq <= r_sumsq + w_chunk_sq;
          r_chunk <= r_chunk + CW'(1);
        end
        S_VAR: begin
          r_mu  <= w_mu;
          r_v   <= w_v;
          r_y   <= '0;
          r_bit <= BIT_W'(Y_W - 1);
        end
        S_ISQRT: begin
          if (w_fit) r_y <= w_t;
          if (r_bit != '0) r_bit <= r_bit - BIT_W'(1);
        end
        S_DONE: begin
          r_mu_out      <= MU_WIDTH'(r_mu);
          r_inv_std_out <= {{(INV_STD_WIDTH - Y_W){1'b0}}, r_y};
          r_stats_done  <= 1'b1;
        end
        default: begin
          r_stats_done <= 1'b0;
        end
      endcase
    end
  end

  assign mu_out      = r_mu_out;
  assign inv_std_out = r_inv_std_out;
  assign stats_done  = r_stats_done;
  // The FSM is already back in IDLE during the stats_done cycle.
  // busy is held through that cycle so that it falls together with stats_done.
  assign busy        = (r_state != S_IDLE) | r_stats_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_layer_norm_stats_unit.sv
module tb_layer_norm_stats_unit;
  localparam int D  = 128;
  localparam int XW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic [D*XW-1:0] x_vec;
  logic [23:0]     mu0, inv0, mu1, inv1;
  logic            done0, done1, busy0, busy1;
  logic [2:0]      st0, st1;

  // dut0 uses EPS=0 and dut1 uses the default EPS=11. Both get the same stimulus.
  layer_norm_stats_unit #(.EPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_stats(start), .x_vector_in(x_vec),
    .mu_out(mu0), .inv_std_out(inv0), .stats_done(done0), .busy(busy0), .dbg_state(st0)
  );
  layer_norm_stats_unit #(.EPS(11)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_stats(start), .x_vector_in(x_vec),
    .mu_out(mu1), .inv_std_out(inv1), .stats_done(done1), .busy(busy1), .dbg_state(st1)
  );

  int      n_cmp  = 0;
  int      n_fail = 0;
  shortint xs[D];
  logic [23:0] m0_mu, m0_inv, m1_mu, m1_inv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic bit fits(input longint y, input longint v);
    logic [127:0] p;
    p = 128'(y) * 128'(y) * 128'(v);
    return p <= (128'd1 << 48);
  endfunction

  function automatic void model(input int eps, output logic [23:0] mu_o, output logic [23:0] inv_o);
    longint s = 0;
    longint sq = 0;
    longint mu, ex2, var_v, v, y;
    foreach (xs[i]) begin
      s  += longint'(xs[i]);
      sq += longint'(xs[i]) * longint'(xs[i]);
    end
    mu    = (s >= 0) ? s / D : -((-s + D - 1) / D);
    ex2   = sq / D;
    var_v = ex2 - mu * mu;
    if (var_v < 0) var_v = 0;
    v = var_v + eps;
    if (v == 0) begin
      y = 64'h7FFFFF;
    end else begin
      y = longint'($rtoi($floor(16777216.0 / $sqrt(real'(v)))));
      if (y > 64'h7FFFFF) y = 64'h7FFFFF;
      while (y > 0 && !fits(y, v)) y--;
      while (y < 64'h7FFFFF && fits(y + 1, v)) y++;
    end
    mu_o  = mu[23:0];
    inv_o = {1'b0, y[22:0]};
  endfunction

  // driver tasks
  task automatic load_vec();
    for (int i = 0; i < D; i++) x_vec[i*XW +: XW] = xs[i];
  endtask

  task automatic run_vec(input string tag, input logic [23:0] e0_mu, input logic [23:0] e0_inv,
                         input logic [23:0] e1_mu, input logic [23:0] e1_inv, input bit pulse_mid);
    int n, busy_cnt, extra;
    load_vec();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (n < 200) begin
      if (busy0) busy_cnt++;
      if (done0) break;
      start = (pulse_mid && n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd41);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd42);
    chk({tag, " done1_aligned"}, 64'(done1), 64'd1);
    chk({tag, " mu eps0"}, 64'(mu0), 64'(e0_mu));
    chk({tag, " inv eps0"}, 64'(inv0), 64'(e0_inv));
    chk({tag, " mu eps11"}, 64'(mu1), 64'(e1_mu));
    chk({tag, " inv eps11"}, 64'(inv1), 64'(e1_inv));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done0), 64'd0);
    chk({tag, " busy_fall"}, 64'(busy0), 64'd0);
    if (pulse_mid) begin
      extra = 0;
      repeat (60) begin
        @(negedge clk);
        if (done0 || done1) extra++;
      end
      chk({tag, " extra_done"}, 64'(extra), 64'd0);
    end
    repeat (3) @(negedge clk);
    chk({tag, " mu_hold"}, 64'(mu0), 64'(e0_mu));
    chk({tag, " inv_hold"}, 64'(inv0), 64'(e0_inv));
  endtask

  task automatic run_model(input string tag, input bit pulse_mid);
    model(0, m0_mu, m0_inv);
    model(11, m1_mu, m1_inv);
    run_vec(tag, m0_mu, m0_inv, m1_mu, m1_inv, pulse_mid);
  endtask

  initial begin
    int n, extra;
    rst_n = 1'b0;
    start = 1'b0;
    x_vec = '0;
    repeat (3) @(negedge clk);
    chk("reset mu", 64'(mu0), 64'd0);
    chk("reset inv", 64'(inv0), 64'd0);
    chk("reset done", 64'(done0), 64'd0);
    chk("reset busy", 64'(busy0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // +-1.0 alternating
    for (int i = 0; i < D; i++) xs[i] = (i % 2 == 0) ? shortint'(16'h0400) : shortint'(16'hFC00);
    model(11, m1_mu, m1_inv);
    run_vec("pm1", 24'h000000, 24'h004000, m1_mu, m1_inv, 1'b0);

    // +-2.0 alternating
    for (int i = 0; i < D; i++) xs[i] = (i % 2 == 0) ? shortint'(16'h0800) : shortint'(16'hF800);
    model(11, m1_mu, m1_inv);
    run_vec("pm2", 24'h000000, 24'h002000, m1_mu, m1_inv, 1'b0);

    // all 1.0
    for (int i = 0; i < D; i++) xs[i] = shortint'(16'h0400);
    model(11, m1_mu, m1_inv);
    run_vec("ones", 24'h000400, 24'h7FFFFF, m1_mu, m1_inv, 1'b0);

    // all -0.5
    for (int i = 0; i < D; i++) xs[i] = shortint'(16'hFE00);
    model(11, m1_mu, m1_inv);
    run_vec("neg_half", 24'hFFFE00, 24'h7FFFFF, m1_mu, m1_inv, 1'b0);

    // single -1 LSB: mu floors to -1, var clamps to 0
    for (int i = 0; i < D; i++) xs[i] = 16'sd0;
    xs[0] = shortint'(16'hFFFF);
    model(11, m1_mu, m1_inv);
    run_vec("floor", 24'hFFFFFF, 24'h7FFFFF, m1_mu, m1_inv, 1'b0);

    // randomized vectors: full range, small range, near-constant
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < D; i++) xs[i] = shortint'($urandom_range(0, 65535));
      run_model($sformatf("rand_full%0d", k), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < D; i++) xs[i] = shortint'(int'($urandom_range(0, 4095)) - 2048);
      run_model($sformatf("rand_small%0d", k), 1'b0);
    end
    begin
      int base;
      base = int'($urandom_range(0, 8000)) - 4000;
      for (int i = 0; i < D; i++) xs[i] = shortint'(base + int'($urandom_range(0, 3)));
      run_model("near_const", 1'b0);
    end

    // start pulse mid-ACCUM is ignored
    for (int i = 0; i < D; i++) xs[i] = shortint'($urandom_range(0, 65535));
    run_model("mid_start", 1'b1);

    // reset mid-run at cycle 20 aborts the run
    for (int i = 0; i < D; i++) xs[i] = shortint'(int'($urandom_range(0, 4095)) - 2048);
    load_vec();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mu0", 64'(mu0), 64'd0);
    chk("rst inv0", 64'(inv0), 64'd0);
    chk("rst inv1", 64'(inv1), 64'd0);
    chk("rst done0", 64'(done0), 64'd0);
    chk("rst busy0", 64'(busy0), 64'd0);
    chk("rst busy1", 64'(busy1), 64'd0);
    chk("rst state", 64'(st0), 64'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0 || done1) extra++;
    end
    chk("rst no_done", 64'(extra), 64'd0);

    // restart with +-1.0: the EPS=11 unit gives floor(2^24/sqrt(2^20+11))
    for (int i = 0; i < D; i++) xs[i] = (i % 2 == 0) ? shortint'(16'h0400) : shortint'(16'hFC00);
    run_vec("pm1_eps", 24'h000000, 24'h004000, 24'h000000, 24'h003FFF, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
